// File: rtl/pe_grid_pkg.sv
// Shared definitions for the PE grid feed path.
//   feed_state_t : sequencer state encoding
//   GRID_ROWS / GRID_COLS / FP16_W : geometry of PE_Grid_12x14 and operand width
//   cfg_legal()  : start-time configuration check
package pe_grid_pkg;

    localparam int GRID_ROWS = 12;
    localparam int GRID_COLS = 14;
    localparam int FP16_W    = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        FLUSH,
        DRAIN
    } feed_state_t;

    // A job needs at least one pass and at least one lane, and no more
    // lanes than the grid has rows.
    function automatic logic cfg_legal(input logic [3:0] outer,
                                       input logic [3:0] inner,
                                       input logic [3:0] max_lane);
        return (outer != 4'd0) && (inner != 4'd0) && (inner <= max_lane);
    endfunction

endpackage

// File: rtl/pe_feed_addr_gen.sv
// Pass/lane counters and buffer address generation for the feed sequencer.
//   clk, rst            : clock, synchronous active-high reset
//   load                : latch cfg and bases, clear counters (job accepted)
//   step                : one element was issued this cycle; advance
//   cfg_outer/cfg_inner : passes and lanes per pass
//   img_base/wgt_base   : buffer base addresses
//   img_addr/wgt_addr   : registered read addresses for the current element
//   col                 : lane index c of the current element
//   last                : current element is the final one of the job
module pe_feed_addr_gen #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [3:0]        cfg_outer,
    input  logic [3:0]        cfg_inner,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] wgt_base,
    output logic [ADDR_W-1:0] img_addr,
    output logic [ADDR_W-1:0] wgt_addr,
    output logic [3:0]        col,
    output logic              last
);

    logic [3:0] outer_q;
    logic [3:0] inner_q;
    logic [3:0] t_q;
    logic [3:0] c_q;

    // Element index t*inner+c grows by exactly one per issued element, so a
    // running address replaces the multiply; ADDR_W overflow gives the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            outer_q  <= '0;
            inner_q  <= '0;
            t_q      <= '0;
            c_q      <= '0;
            img_addr <= '0;
            wgt_addr <= '0;
        end else if (load) begin
            outer_q  <= cfg_outer;
            inner_q  <= cfg_inner;
            t_q      <= '0;
            c_q      <= '0;
            img_addr <= img_base;
            wgt_addr <= wgt_base;
        end else if (step && !last) begin
            img_addr <= img_addr + ADDR_W'(1);
            wgt_addr <= wgt_addr + ADDR_W'(1);
            if (c_q == inner_q - 4'd1) begin
                c_q <= '0;
                t_q <= t_q + 4'd1;
            end else begin
                c_q <= c_q + 4'd1;
            end
        end
    end

    assign col  = c_q;
    assign last = (t_q == outer_q - 4'd1) && (c_q == inner_q - 4'd1);

endmodule

// File: rtl/pe_grid_feed_ctrl.sv
// Feed sequencer: streams image and kernel operands from two buffers with
// 1-cycle synchronous reads onto the x/y multicast buses of PE_Grid_12x14,
// then waits a programmable drain interval before pulsing done.
//   start, cfg_*                  : job request and configuration (latched on accept)
//   img_rd_en/addr, img_rd_data   : image buffer read port
//   wgt_rd_en/addr, wgt_rd_data   : kernel buffer read port
//   image_val_in, tag_col, valid_x: grid x bus
//   weight_val_in, tag_row, valid_y: grid y bus
//   busy, done, cfg_err           : job status
module pe_grid_feed_ctrl
    import pe_grid_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int TAG_W    = 4,
    parameter int ADDR_W   = 10,
    parameter int MAX_LANE = GRID_ROWS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        cfg_outer,
    input  logic [3:0]        cfg_inner,
    input  logic [4:0]        cfg_drain,
    input  logic [ADDR_W-1:0] cfg_img_base,
    input  logic [ADDR_W-1:0] cfg_wgt_base,
    output logic              img_rd_en,
    output logic [ADDR_W-1:0] img_rd_addr,
    input  logic [DATA_W-1:0] img_rd_data,
    output logic              wgt_rd_en,
    output logic [ADDR_W-1:0] wgt_rd_addr,
    input  logic [DATA_W-1:0] wgt_rd_data,
    output logic [DATA_W-1:0] image_val_in,
    output logic [TAG_W-1:0]  tag_col,
    output logic              valid_x,
    output logic [DATA_W-1:0] weight_val_in,
    output logic [TAG_W-1:0]  tag_row,
    output logic              valid_y,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam logic [3:0] MAX_LANE_L = 4'(MAX_LANE);

    feed_state_t       state;
    logic              issue_en;
    logic [4:0]        drain_q;
    logic [4:0]        drain_cnt;
    logic              accept;
    logic [3:0]        ag_col;
    logic              ag_last;
    logic              vld_p1;
    logic [TAG_W-1:0]  tag_p1;
    logic [DATA_W-1:0] img_hold;
    logic [DATA_W-1:0] wgt_hold;

    // The done cycle is already IDLE but must not accept a new job.
    assign accept = (state == IDLE) && start && !done &&
                    cfg_legal(cfg_outer, cfg_inner, MAX_LANE_L);

    pe_feed_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      (issue_en),
        .cfg_outer (cfg_outer),
        .cfg_inner (cfg_inner),
        .img_base  (cfg_img_base),
        .wgt_base  (cfg_wgt_base),
        .img_addr  (img_rd_addr),
        .wgt_addr  (wgt_rd_addr),
        .col       (ag_col),
        .last      (ag_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            issue_en  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            drain_q   <= '0;
            drain_cnt <= '0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= ISSUE;
                        issue_en <= 1'b1;
                        busy     <= 1'b1;
                        drain_q  <= cfg_drain;
                    end else if (start && !done) begin
                        cfg_err <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (ag_last) begin
                        issue_en <= 1'b0;
                        state    <= FLUSH;
                    end
                end
                FLUSH: begin
                    // The last element's valid is on the bus this cycle.
                    if (drain_q == 5'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state     <= DRAIN;
                        drain_cnt <= drain_q;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - 5'd1;
                    if (drain_cnt == 5'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- stage p1: bus cycle, one cycle after the read strobe ----
    // The buffer's own output register supplies the operand in the valid
    // cycle; the hold registers keep the bus steady once valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            tag_p1   <= '0;
            img_hold <= '0;
            wgt_hold <= '0;
        end else begin
            vld_p1 <= issue_en;
            if (issue_en) begin
                tag_p1 <= TAG_W'(ag_col);
            end
            if (vld_p1) begin
                img_hold <= img_rd_data;
                wgt_hold <= wgt_rd_data;
            end
        end
    end

    assign img_rd_en     = issue_en;
    assign wgt_rd_en     = issue_en;
    assign valid_x       = vld_p1;
    assign valid_y       = vld_p1;
    assign tag_col       = tag_p1;
    assign tag_row       = tag_p1;
    assign image_val_in  = vld_p1 ? img_rd_data : img_hold;
    assign weight_val_in = vld_p1 ? wgt_rd_data : wgt_hold;

endmodule

// File: tb/tb_pe_grid_feed_ctrl.sv
module tb_pe_grid_feed_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  cfg_outer;
    logic [3:0]  cfg_inner;
    logic [4:0]  cfg_drain;
    logic [9:0]  cfg_img_base;
    logic [9:0]  cfg_wgt_base;
    logic        img_rd_en;
    logic [9:0]  img_rd_addr;
    logic [15:0] img_rd_data;
    logic        wgt_rd_en;
    logic [9:0]  wgt_rd_addr;
    logic [15:0] wgt_rd_data;
    logic [15:0] image_val_in;
    logic [3:0]  tag_col;
    logic        valid_x;
    logic [15:0] weight_val_in;
    logic [3:0]  tag_row;
    logic        valid_y;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] img_mem [1024];
    logic [15:0] wgt_mem [1024];

    always #5 clk = ~clk;

    pe_grid_feed_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_outer(cfg_outer), .cfg_inner(cfg_inner), .cfg_drain(cfg_drain),
        .cfg_img_base(cfg_img_base), .cfg_wgt_base(cfg_wgt_base),
        .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr), .img_rd_data(img_rd_data),
        .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
        .image_val_in(image_val_in), .tag_col(tag_col), .valid_x(valid_x),
        .weight_val_in(weight_val_in), .tag_row(tag_row), .valid_y(valid_y),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    // Buffer SRAMs: 1-cycle synchronous read, output held between reads.
    always @(posedge clk) begin
        if (img_rd_en) img_rd_data <= img_mem[img_rd_addr];
        if (wgt_rd_en) wgt_rd_data <= wgt_mem[wgt_rd_addr];
    end

    // One job: cycle 0 is the start cycle. Every cycle is compared with the
    // timeline derived from outer*inner and drain. poke_busy drives an illegal
    // start mid-job; poke_done drives a legal start on the done cycle.
    task automatic run(input int outer, input int inner, input int drain,
                       input int ibase, input int wbase,
                       input bit poke_busy, input bit poke_done, input string nm);
        int n_el;
        int k;
        logic [9:0]  e_ia, e_wa;
        logic [15:0] e_img, e_wgt;
        logic [3:0]  e_tag;
        logic e_rd, e_vld, e_busy, e_done;
        n_el = outer * inner;
        @(negedge clk);
        start = 1'b1;
        cfg_outer = 4'(outer); cfg_inner = 4'(inner); cfg_drain = 5'(drain);
        cfg_img_base = 10'(ibase); cfg_wgt_base = 10'(wbase);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= n_el + drain + 5; n++) begin
            e_rd   = (n >= 1) && (n <= n_el);
            e_vld  = (n >= 2) && (n <= n_el + 1);
            e_busy = (n >= 1) && (n <= n_el + 1 + drain);
            e_done = (n == n_el + 2 + drain);
            checks++;
            if (img_rd_en !== e_rd || wgt_rd_en !== e_rd) begin
                errors++;
                $display("FAIL %s rd_en n=%0d: got %b/%b want %b", nm, n, img_rd_en, wgt_rd_en, e_rd);
            end
            if (e_rd) begin
                e_ia = 10'(ibase + n - 1);
                e_wa = 10'(wbase + n - 1);
                checks++;
                if (img_rd_addr !== e_ia || wgt_rd_addr !== e_wa) begin
                    errors++;
                    $display("FAIL %s rd_addr n=%0d: got %h/%h want %h/%h", nm, n, img_rd_addr, wgt_rd_addr, e_ia, e_wa);
                end
            end
            checks++;
            if (valid_x !== e_vld || valid_y !== e_vld) begin
                errors++;
                $display("FAIL %s valid n=%0d: got %b/%b want %b", nm, n, valid_x, valid_y, e_vld);
            end
            if (n >= 2) begin
                k = e_vld ? n - 2 : n_el - 1;
                e_img = img_mem[10'(ibase + k)];
                e_wgt = wgt_mem[10'(wbase + k)];
                e_tag = 4'(k % inner);
                checks++;
                if (image_val_in !== e_img || weight_val_in !== e_wgt) begin
                    errors++;
                    $display("FAIL %s data n=%0d: got %h/%h want %h/%h", nm, n, image_val_in, weight_val_in, e_img, e_wgt);
                end
                checks++;
                if (tag_col !== e_tag || tag_row !== e_tag) begin
                    errors++;
                    $display("FAIL %s tag n=%0d: got %0d/%0d want %0d", nm, n, tag_col, tag_row, e_tag);
                end
            end
            checks++;
            if (busy !== e_busy || done !== e_done || cfg_err !== 1'b0) begin
                errors++;
                $display("FAIL %s status n=%0d: got busy=%b done=%b err=%b want busy=%b done=%b err=0",
                         nm, n, busy, done, cfg_err, e_busy, e_done);
            end
            // stimulus for the next cycle
            start = 1'b0;
            if (poke_busy && n == 3) begin
                start = 1'b1; cfg_outer = 4'd0; cfg_inner = 4'd13;
                cfg_img_base = 10'h155; cfg_wgt_base = 10'h2AA;
            end
            if (poke_done && n == n_el + 2 + drain) begin
                start = 1'b1; cfg_outer = 4'd2; cfg_inner = 4'd2;
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        cfg_outer = '0; cfg_inner = '0; cfg_drain = '0; cfg_img_base = '0; cfg_wgt_base = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({img_rd_en, wgt_rd_en, valid_x, valid_y, busy, done, cfg_err} !== 7'b0 ||
            img_rd_addr !== 10'd0 || wgt_rd_addr !== 10'd0 || image_val_in !== 16'd0 ||
            weight_val_in !== 16'd0 || tag_col !== 4'd0 || tag_row !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b%b v=%b%b busy=%b done=%b err=%b addr=%h/%h data=%h/%h tag=%0d/%0d want all 0",
                     img_rd_en, wgt_rd_en, valid_x, valid_y, busy, done, cfg_err,
                     img_rd_addr, wgt_rd_addr, image_val_in, weight_val_in, tag_col, tag_row);
        end
        rst = 1'b0;
    endtask

    task automatic test_cfg_err(input int outer, input int inner);
        @(negedge clk);
        start = 1'b1; cfg_outer = 4'(outer); cfg_inner = 4'(inner); cfg_drain = 5'd3;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || img_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_pulse o=%0d i=%0d: got err=%b busy=%b rd=%b want 1/0/0", outer, inner, cfg_err, busy, img_rd_en);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (cfg_err !== 1'b0 || busy !== 1'b0 || img_rd_en !== 1'b0 || valid_x !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_after o=%0d i=%0d: got err=%b busy=%b rd=%b v=%b want 0", outer, inner, cfg_err, busy, img_rd_en, valid_x);
            end
        end
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        bit hit = 0;
        @(negedge clk);
        start = 1'b1; cfg_outer = 4'd6; cfg_inner = 4'd6; cfg_drain = 5'd10;
        cfg_img_base = 10'h000; cfg_wgt_base = 10'h100;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (valid_x === 1'b1) nv++;
            if (nv == 10) hit = 1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_wait: got %0d valids want 10", nv);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({img_rd_en, wgt_rd_en, valid_x, valid_y, busy, done, cfg_err} !== 7'b0 ||
            img_rd_addr !== 10'd0 || image_val_in !== 16'd0 || weight_val_in !== 16'd0 || tag_col !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got en=%b v=%b busy=%b addr=%h data=%h/%h tag=%0d want all 0",
                     img_rd_en, valid_x, busy, img_rd_addr, image_val_in, weight_val_in, tag_col);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (img_rd_en !== 1'b0 || valid_x !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_idle: got rd=%b v=%b busy=%b want 0", img_rd_en, valid_x, busy);
            end
        end
        run(6, 6, 10, 'h000, 'h100, 0, 0, "replay");
    endtask

    task automatic test_random();
        int o, i, d;
        for (int r = 0; r < 4; r++) begin
            o = $urandom_range(14, 1);
            i = $urandom_range(12, 1);
            d = $urandom_range(31, 0);
            run(o, i, d, $urandom_range(1023, 0), $urandom_range(1023, 0), r[0], r[1], "random");
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) begin
            img_mem[a] = 16'($urandom);
            wgt_mem[a] = 16'($urandom);
        end
        img_rd_data = '0;
        wgt_rd_data = '0;
        test_reset();
        run(6, 6, 10, 'h000, 'h100, 0, 0, "pass6x6");
        run(1, 1, 0, 'h010, 'h020, 0, 0, "single");
        run(3, 12, $urandom_range(31, 0), $urandom_range(1023, 0), $urandom_range(1023, 0), 0, 0, "pass3x12");
        test_cfg_err(3, 13);
        test_cfg_err(3, 0);
        test_cfg_err(0, 4);
        run(4, 5, 3, 'h040, 'h080, 1, 0, "start_busy");
        run(2, 3, 0, 'h070, 'h090, 0, 1, "start_done");
        run(1, 4, 2, 'h3FE, 'h3FF, 0, 0, "wrap");
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
